alu_mc: RTL and testbench

Multi-cycle, handshaked successor to the combinational `alu`. It keeps the eight existing operations at their original 3-bit encodings and adds arithmetic right shift, unsigned compare, and iterative unsigned multiply, divide and remainder. It is parametrised in width and exposes a full flag set. It sits between the decode/issue stage and writeback, with valid/ready on both sides, so a long operation stalls issue instead of stretching the clock.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_iter.sv | 100 ++++++++++
 rtl/alu_mc.sv | 168 ++++++++++++++++
 tb/tb_alu_mc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the multi-cycle ALU (alu_mc).
//   alu_op_e    - 4-bit opcode; 0000..0111 keep the legacy 3-bit ALU encodings.
//   alu_state_e - handshake FSM states (IDLE, BUSY, DONE).
//   alu_flags_t - registered flag bundle {z, n, c, v, dz, err}.
//   ALU_N       - default operand width.
//   ALU_CTR_W   - iteration counter width for the default width.
//   ALU_DIV0_Q  - quotient returned on divide by zero (all ones; slice to N).
package alu_pkg;

  localparam int ALU_N     = 32;
  localparam int ALU_N_MAX = 64;
  localparam int ALU_CTR_W = $clog2(ALU_N);
  localparam logic [ALU_N_MAX-1:0] ALU_DIV0_Q = '1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101,
    OP_RSV0  = 4'b1110,
    OP_RSV1  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
    logic dz;
    logic err;
  } alu_flags_t;

  function automatic logic op_is_iter(input alu_op_e op);
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  endfunction

  function automatic logic op_is_div(input alu_op_e op);
    return op inside {OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_iter.sv
// alu_iter: iterative unsigned multiply / restoring divide engine.
// A start pulse captures the operands and runs N single-bit steps sharing one
// 2N-bit accumulator: {high product, low product} or {remainder, quotient}.
// done is high during the cycle that performs the last step; hi/lo present the
// outcome of the step being performed, so they are final while done is high.
//   clk, rst_n     - clock, asynchronous active-low reset (aborts a run)
//   start          - load operands and begin (ignored fields when not set)
//   op             - MUL/MULHU select multiply, DIVU/REMU select divide
//   a, b           - operands (a*b, or a/b with b nonzero)
//   done           - last step in progress this cycle
//   hi, lo         - product high/low, or remainder/quotient
module alu_iter
  import alu_pkg::*;
#(
  parameter int N = ALU_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  alu_op_e      op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);

  logic [2*N-1:0] acc_q, acc_d, step;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]  ctr_q, ctr_d;
  logic           run_q, run_d;
  logic           is_div_q, is_div_d;

  logic [N:0] mul_sum;
  logic [N:0] div_shift;
  logic [N:0] div_diff;
  logic       div_ge;

  // Multiply: add the multiplicand into the high half when the low bit is set,
  // then shift the whole product right, carry included.
  assign mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring divide: shift {rem, quo} left; subtract the divisor when it fits.
  assign div_shift = acc_q[2*N-1:N-1];
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign step = is_div_q
              ? {(div_ge ? div_diff[N-1:0] : div_shift[N-1:0]), acc_q[N-2:0], div_ge}
              : {mul_sum, acc_q[N-1:1]};

  assign done = run_q && (ctr_q == '0);
  assign hi   = step[2*N-1:N];
  assign lo   = step[N-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    ctr_d    = ctr_q;
    run_d    = run_q;
    is_div_d = is_div_q;
    if (start) begin
      is_div_d = op_is_div(op);
      acc_d    = op_is_div(op) ? {{N{1'b0}}, a} : {{N{1'b0}}, b};
      opnd_d   = op_is_div(op) ? b : a;
      ctr_d    = CW'(N - 1);
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d = step;
      if (ctr_q == '0) begin
        run_d = 1'b0;
      end else begin
        ctr_d = ctr_q - 1'b1;
      end
    end
  end

  // NOTE: the datapath registers are reset along with control so a run aborted
  // by reset leaves nothing behind; they are few, so the reset fan-out is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      ctr_q    <= '0;
      run_q    <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      ctr_q    <= ctr_d;
      run_q    <= run_d;
      is_div_q <= is_div_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle handshaked ALU between issue and writeback.
// Single-cycle ops, reserved ops and divide-by-zero finish one cycle after
// accept; MUL/MULHU/DIVU/REMU iterate N steps in alu_iter.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - operand handshake; ready only in IDLE
//   a, b, alucontrol      - operands and opcode (shift amount is b[log2 N-1:0])
//   out_valid / out_ready - result handshake; valid only in DONE
//   result                - registered result
//   fZ fN fC fV fDZ fERR  - registered flags
module alu_mc
  import alu_pkg::*;
#(
  parameter int N = ALU_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alucontrol,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         fZ,
  output logic         fN,
  output logic         fC,
  output logic         fV,
  output logic         fDZ,
  output logic         fERR
);

  localparam int SW = $clog2(N);

  alu_state_e state_q, state_d;
  alu_op_e    op_q, op_d;
  alu_flags_t flags_q, flags_d;
  logic [N-1:0] result_q, result_d;

  alu_op_e      op_in;
  logic [SW-1:0] shamt;
  logic [N:0]   add_w, sub_w;
  logic [N-1:0] sc_res, it_res;
  logic         sc_c, sc_v, sc_dz, sc_err;
  logic         accept, start, it_done;
  logic [N-1:0] it_hi, it_lo;

  assign op_in  = alu_op_e'(alucontrol);
  assign shamt  = b[SW-1:0];
  assign accept = in_valid && (state_q == ST_IDLE);
  assign add_w  = {1'b0, a} + {1'b0, b};
  // Carry out of a + ~b + 1 is the no-borrow bit.
  assign sub_w  = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);

  alu_iter #(.N(N)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op_in),
    .a     (a),
    .b     (b),
    .done  (it_done),
    .hi    (it_hi),
    .lo    (it_lo)
  );

  assign it_res = (op_q == OP_MUL || op_q == OP_DIVU) ? it_lo : it_hi;

  // Single-cycle datapath; DIVU/REMU land here only when b is zero.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_dz  = 1'b0;
    sc_err = 1'b0;
    case (op_in)
      OP_ADD: begin
        sc_res = add_w[N-1:0];
        sc_c   = add_w[N];
        sc_v   = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[N-1:0];
        sc_c   = sub_w[N];
        sc_v   = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      OP_SLT:  sc_res = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(N-1){1'b0}}, a < b};
      OP_DIVU: begin
        sc_res = ALU_DIV0_Q[N-1:0];
        sc_dz  = 1'b1;
      end
      OP_REMU: begin
        sc_res = a;
        sc_dz  = 1'b1;
      end
      OP_MUL, OP_MULHU: sc_res = '0;
      default: sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = op_in;
          if (op_is_iter(op_in) && !(op_is_div(op_in) && (b == '0))) begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            result_d = sc_res;
            flags_d  = '{z: (sc_res == '0), n: sc_res[N-1], c: sc_c, v: sc_v,
                         dz: sc_dz, err: sc_err};
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (it_done) begin
          result_d = it_res;
          flags_d  = '{z: (it_res == '0), n: it_res[N-1], c: 1'b0, v: 1'b0,
                       dz: 1'b0, err: 1'b0};
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign fZ        = flags_q.z;
  assign fN        = flags_q.n;
  assign fC        = flags_q.c;
  assign fV        = flags_q.v;
  assign fDZ       = flags_q.dz;
  assign fERR      = flags_q.err;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed, table-driven bench for alu_mc at N=32, plus hand-written
// sequences for backpressure, turnaround and reset during an iterative op.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] a, b, result;
  logic [3:0]   alucontrol;
  logic         fZ, fN, fC, fV, fDZ, fERR;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_mc #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .fZ         (fZ),
    .fN         (fN),
    .fC         (fC),
    .fV         (fV),
    .fDZ        (fDZ),
    .fERR       (fERR)
  );

  always #5 clk = ~clk;

  // Flags packed as {z, n, c, v, dz, err}.
  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic [5:0]   flg;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] flags_now();
    return {fZ, fN, fC, fV, fDZ, fERR};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [N-1:0] va, input logic [N-1:0] vb,
                         input logic [N-1:0] res, input logic [5:0] flg, input int lat);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = res; v.flg = flg; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one op, measure latency (edges from accept to the first edge that
  // sees out_valid), check result/flags, optionally hold out_ready low for
  // 'hold' cycles while presenting a competing op, then complete the handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [N-1:0] va,
                        input logic [N-1:0] vb, input logic [N-1:0] res,
                        input logic [5:0] flg, input int lat, input int hold);
    int  n;
    bit  busy_ok;
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; a = va; b = vb; alucontrol = op;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
      if (in_ready) busy_ok = 1'b0;
    end while (!out_valid && n < 100);
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, result, res);
    check({tag, "_flg"}, flags_now(), flg);
    check({tag, "_nordy"}, busy_ok, 1'b1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222; alucontrol = OP_SUB;
      @(negedge clk);
      check($sformatf("%s_hold%0d_v", tag, i), {out_valid, in_ready}, 2'b10);
      check($sformatf("%s_hold%0d_res", tag, i), result, res);
      check($sformatf("%s_hold%0d_flg", tag, i), flags_now(), flg);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    // Handshake done: idle and ready again, nothing new in flight.
    check({tag, "_post"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int  n;
    bit  stale;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alucontrol = '0;

    // Single-cycle and reserved ops.
    add_vec(OP_ADD,  32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 6'b010000, 1);
    add_vec(OP_SUB,  32'h8765_4321, 32'h1234_5678, 32'h7530_ECA9, 6'b001100, 1);
    add_vec(OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 6'b010000, 1);
    add_vec(OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 6'b000000, 1);
    add_vec(OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 6'b000000, 1);
    add_vec(OP_OR,   32'h0000_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF, 6'b010000, 1);
    add_vec(OP_XOR,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 6'b100000, 1);
    add_vec(OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 6'b000000, 1);
    add_vec(OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 6'b000000, 1);
    add_vec(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 6'b000000, 1);
    add_vec(OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 6'b100000, 1);
    add_vec(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 6'b101000, 1);
    add_vec(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 6'b010100, 1);
    add_vec(OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 6'b101000, 1);
    add_vec(OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 6'b010000, 1);
    add_vec(4'b1110, 32'h1234_5678, 32'h1,         32'h0000_0000, 6'b100001, 1);
    add_vec(4'b1111, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 6'b100001, 1);
    // Divide by zero completes without iterating.
    add_vec(OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 6'b010010, 1);
    add_vec(OP_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 6'b000010, 1);
    // Iterative ops: N+1 cycles.
    add_vec(OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 6'b100000, 33);
    add_vec(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 6'b000000, 33);
    add_vec(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 6'b000000, 33);
    add_vec(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'b010000, 33);
    add_vec(OP_DIVU,  32'd100,       32'd7,         32'd14,        6'b000000, 33);
    add_vec(OP_REMU,  32'd100,       32'd7,         32'd2,         6'b000000, 33);
    add_vec(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 6'b010000, 33);
    add_vec(OP_REMU,  32'd7,         32'd100,       32'd7,         6'b000000, 33);

    // Reset state, observed while reset is still asserted.
    repeat (3) @(negedge clk);
    check("rst_hs", {out_valid, in_ready}, 2'b01);
    check("rst_res", result, 32'h0);
    check("rst_flg", flags_now(), 6'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_hs", {out_valid, in_ready}, 2'b01);

    foreach (vecs[i])
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].flg, vecs[i].lat, 0);

    // Backpressure on a single-cycle and an iterative result.
    run_op("bp_add", OP_ADD, 32'd1, 32'd2, 32'd3, 6'b000000, 1, 5);
    run_op("bp_div", OP_DIVU, 32'd100, 32'd7, 32'd14, 6'b000000, 33, 5);

    // Reset 10 cycles into a MUL: aborted with no output ever appearing.
    @(negedge clk);
    in_valid = 1'b1; a = 32'd3; b = 32'd5; alucontrol = OP_MUL;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mr_busy", {out_valid, in_ready}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("mr_rst_hs", {out_valid, in_ready}, 2'b01);
    check("mr_rst_res", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || result != '0 || !in_ready) stale = 1'b1;
      n++;
    end
    check("mr_no_stale", stale, 1'b0);
    run_op("mr_add", OP_ADD, 32'd1, 32'd1, 32'd2, 6'b000000, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
